// File: rtl/i2c_passthru_pkg.sv
// Shared encodings for the I2C passthrough rx/tx controller and bit transmitter.
package i2c_passthru_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_VAL  = 3'd1,
        ST_LOAD      = 3'd2,
        ST_WAIT_RISE = 3'd3,
        ST_WAIT_FALL = 3'd4,
        ST_HOLD      = 3'd5
    } state_t;

endpackage

// File: rtl/i2c_passthru_cyc_cnt.sv
// Saturating cycle counter with synchronous clear and a terminal-match flag.
module i2c_passthru_cyc_cnt
    import i2c_passthru_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_term,
    output logic             o_match
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            cnt <= '0;
        end else if (i_en && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_match = (cnt == i_term);

endmodule

// File: rtl/i2c_passthru_bit_tx.sv
// Per-bit SDA transmitter: replays a sampled source bit onto the target channel's SDA.
// Optional wait-state timeout: define I2C_PASSTHRU_BIT_TX_TIMEOUT_EN.
module i2c_passthru_bit_tx
    import i2c_passthru_pkg::*;
#(
    parameter int HOLD_CYC    = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_tx_to_mst,
    input  logic i_abort,
    input  logic i_bit_valid,
    input  logic i_bit,
    input  logic i_cha_scl,
    input  logic i_cha_sda,
    input  logic i_chb_scl,
    input  logic i_chb_sda,
    output logic o_cha_sda_oe,
    output logic o_chb_sda_oe,
    output logic o_tx_done,
    output logic o_sda_mismatch,
    output logic o_timeout
);

    localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'((HOLD_CYC == 0) ? 0 : HOLD_CYC - 1);

    state_t st;
    logic   sel;
    logic   bit_q;
    logic   chk_pend;
    logic   tgt_scl;
    logic   tgt_sda;
    logic   leave;
    logic   hold_done;
    logic   to_hit;

    assign tgt_scl = sel ? i_cha_scl : i_chb_scl;
    assign tgt_sda = sel ? i_cha_sda : i_chb_sda;

    // Exit condition of the current wait state; also restarts the timeout counter.
    always_comb begin
        leave = 1'b0;
        case (st)
            ST_WAIT_VAL:  leave = i_bit_valid;
            ST_LOAD:      leave = !tgt_scl;
            ST_WAIT_RISE: leave = tgt_scl;
            ST_WAIT_FALL: leave = !tgt_scl;
            default:      leave = 1'b0;
        endcase
    end

    i2c_passthru_cyc_cnt u_hold_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (st != ST_HOLD),
        .i_en    (st == ST_HOLD),
        .i_term  (HOLD_TERM),
        .o_match (hold_done)
    );

`ifdef I2C_PASSTHRU_BIT_TX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_TERM = CNT_W'(TIMEOUT_CYC - 1);

    logic in_wait;
    logic to_match;

    assign in_wait = (st == ST_WAIT_VAL) || (st == ST_LOAD) ||
                     (st == ST_WAIT_RISE) || (st == ST_WAIT_FALL);

    i2c_passthru_cyc_cnt u_wait_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (!in_wait || leave || i_abort),
        .i_en    (in_wait),
        .i_term  (TO_TERM),
        .o_match (to_match)
    );

    // A legitimate exit in the same cycle takes precedence over the timeout.
    assign to_hit = in_wait && !leave && to_match;
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            st             <= ST_IDLE;
            sel            <= 1'b0;
            bit_q          <= 1'b0;
            chk_pend       <= 1'b0;
            o_cha_sda_oe   <= 1'b0;
            o_chb_sda_oe   <= 1'b0;
            o_tx_done      <= 1'b1;
            o_sda_mismatch <= 1'b0;
            o_timeout      <= 1'b0;
        end else begin
            o_sda_mismatch <= 1'b0;
            o_timeout      <= 1'b0;
            if (i_abort || to_hit) begin
                st           <= ST_IDLE;
                chk_pend     <= 1'b0;
                o_cha_sda_oe <= 1'b0;
                o_chb_sda_oe <= 1'b0;
                o_tx_done    <= 1'b1;
                o_timeout    <= !i_abort;
            end else begin
                case (st)
                    // oe keep their value here so the bit is held across the boundary.
                    ST_IDLE: if (i_start) begin
                        sel       <= i_tx_to_mst;
                        st        <= ST_WAIT_VAL;
                        o_tx_done <= 1'b0;
                    end
                    ST_WAIT_VAL: if (leave) begin
                        bit_q <= i_bit;
                        st    <= ST_LOAD;
                    end
                    ST_LOAD: if (leave) begin
                        o_cha_sda_oe <= sel ? ~bit_q : 1'b0;
                        o_chb_sda_oe <= sel ? 1'b0 : ~bit_q;
                        st           <= ST_WAIT_RISE;
                    end
                    ST_WAIT_RISE: if (leave) begin
                        chk_pend <= 1'b1;
                        st       <= ST_WAIT_FALL;
                    end
                    ST_WAIT_FALL: begin
                        chk_pend <= 1'b0;
                        if (chk_pend && bit_q && !tgt_sda)
                            o_sda_mismatch <= 1'b1;
                        if (leave) begin
                            if (HOLD_CYC == 0) begin
                                st        <= ST_IDLE;
                                o_tx_done <= 1'b1;
                            end else begin
                                st <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: if (hold_done) begin
                        st        <= ST_IDLE;
                        o_tx_done <= 1'b1;
                    end
                    default: begin
                        st        <= ST_IDLE;
                        o_tx_done <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_passthru_bit_tx.sv
// Directed bench for i2c_passthru_bit_tx: HOLD_CYC=4 and HOLD_CYC=0 instances share stimulus.
module tb_i2c_passthru_bit_tx;

    logic clk = 1'b0;
    logic rst, start, tx_to_mst, abort, bit_valid, bitv;
    logic cha_scl, cha_sda, chb_scl, chb_sda;
    logic a_oe, b_oe, done, mis, tmo;
    logic a_oe0, b_oe0, done0, mis0, tmo0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    i2c_passthru_bit_tx #(.HOLD_CYC(4), .TIMEOUT_CYC(100)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_tx_to_mst(tx_to_mst),
        .i_abort(abort), .i_bit_valid(bit_valid), .i_bit(bitv),
        .i_cha_scl(cha_scl), .i_cha_sda(cha_sda), .i_chb_scl(chb_scl), .i_chb_sda(chb_sda),
        .o_cha_sda_oe(a_oe), .o_chb_sda_oe(b_oe), .o_tx_done(done),
        .o_sda_mismatch(mis), .o_timeout(tmo)
    );

    i2c_passthru_bit_tx #(.HOLD_CYC(0), .TIMEOUT_CYC(100)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_tx_to_mst(tx_to_mst),
        .i_abort(abort), .i_bit_valid(bit_valid), .i_bit(bitv),
        .i_cha_scl(cha_scl), .i_cha_sda(cha_sda), .i_chb_scl(chb_scl), .i_chb_sda(chb_sda),
        .o_cha_sda_oe(a_oe0), .o_chb_sda_oe(b_oe0), .o_tx_done(done0),
        .o_sda_mismatch(mis0), .o_timeout(tmo0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic set_scl(input logic mst, input logic v);
        if (mst) cha_scl = v;
        else     chb_scl = v;
    endtask

    // Leaves the DUT in LOAD with the target SCL already low.
    task automatic begin_bit(input logic mst, input logic b);
        tx_to_mst = mst;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        bit_valid = 1'b1;
        bitv      = b;
        tick();
        bit_valid = 1'b0;
        set_scl(mst, 1'b0);
    endtask

    // Raises target SCL, spends one cycle in WAIT_FALL, then drops SCL for the next edge.
    task automatic rise_fall(input logic mst);
        set_scl(mst, 1'b1);
        tick();
        tick();
        set_scl(mst, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; tx_to_mst = 1'b0; abort = 1'b0;
        bit_valid = 1'b0; bitv = 1'b0;
        cha_scl = 1'b1; cha_sda = 1'b1; chb_scl = 1'b1; chb_sda = 1'b1;
        tick();
        tick();
        chk("rst_a_oe", a_oe, 1'b0);
        chk("rst_b_oe", b_oe, 1'b0);
        chk("rst_done", done, 1'b1);
        chk("rst_mis", mis, 1'b0);
        chk("rst_tmo", tmo, 1'b0);
        rst = 1'b0;
        tick();

        // Bit 0 to B
        begin_bit(1'b0, 1'b0);
        chk("t1_done_low", done, 1'b0);
        tick();
        chk("t1_b_oe", b_oe, 1'b1);
        chk("t1_a_oe", a_oe, 1'b0);
        rise_fall(1'b0);
        chk("t1_no_mis", mis, 1'b0);
        tick();
        chk("t1_e0_done", done, 1'b0);
        chk("t1_h0_done", done0, 1'b1);
        tick(); chk("t1_e1_done", done, 1'b0);
        tick(); chk("t1_e2_done", done, 1'b0);
        tick(); chk("t1_e3_done", done, 1'b0);
        tick(); chk("t1_e4_done", done, 1'b1);
        chk("t1_b_oe_held", b_oe, 1'b1);

        // Bit 1 to A with A SDA held low during SCL high
        begin_bit(1'b1, 1'b1);
        tick();
        chk("t2_a_oe", a_oe, 1'b0);
        chk("t2_b_oe", b_oe, 1'b0);
        cha_sda = 1'b0;
        rise_fall(1'b1);
        chk("t2_mis", mis, 1'b1);
        chk("t2_mis_h0", mis0, 1'b1);
        tick();
        chk("t2_mis_once", mis, 1'b0);
        cha_sda = 1'b1;
        repeat (4) tick();
        chk("t2_done", done, 1'b1);

        // Direction switch B then A
        begin_bit(1'b0, 1'b0);
        tick();
        rise_fall(1'b0);
        repeat (5) tick();
        begin_bit(1'b1, 1'b0);
        chk("t3_pre_b_oe", b_oe, 1'b1);
        chk("t3_pre_a_oe", a_oe, 1'b0);
        tick();
        chk("t3_b_oe", b_oe, 1'b0);
        chk("t3_a_oe", a_oe, 1'b1);
        rise_fall(1'b1);
        repeat (5) tick();
        chk("t3_done", done, 1'b1);

        // Abort during WAIT_FALL, then start+abort together
        begin_bit(1'b1, 1'b0);
        tick();
        cha_scl = 1'b1;
        tick();
        chk("t4_a_oe_on", a_oe, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_a_oe", a_oe, 1'b0);
        chk("t4_b_oe", b_oe, 1'b0);
        chk("t4_done", done, 1'b1);
        chk("t4_done_h0", done0, 1'b1);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("t4_sa_done", done, 1'b1);
        tick();
        chk("t4_sa_idle", done, 1'b1);

        // Starts while busy are ignored
        begin_bit(1'b0, 1'b0);
        start = 1'b1; tx_to_mst = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_b_oe", b_oe, 1'b1);
        chk("t5_a_oe", a_oe, 1'b0);
        chk("t5_done", done, 1'b0);
        rise_fall(1'b0);
        tick();
        chk("t5_h0_done", done0, 1'b1);
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_e3_done", done, 1'b0);
        tick();
        chk("t5_e4_done", done, 1'b1);
        tick();
        chk("t5_stay_idle", done, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // SCL stuck high in WAIT_FALL
        begin_bit(1'b1, 1'b0);
        tick();
        cha_scl = 1'b1;
        tick();
`ifdef I2C_PASSTHRU_BIT_TX_TIMEOUT_EN
        repeat (99) tick();
        chk("t6_tmo_pre", tmo, 1'b0);
        chk("t6_a_oe_pre", a_oe, 1'b1);
        tick();
        chk("t6_tmo", tmo, 1'b1);
        chk("t6_tmo_h0", tmo0, 1'b1);
        chk("t6_a_oe", a_oe, 1'b0);
        chk("t6_b_oe", b_oe, 1'b0);
        chk("t6_done", done, 1'b1);
        tick();
        chk("t6_tmo_pulse", tmo, 1'b0);
`else
        repeat (120) tick();
        chk("t6_no_tmo", tmo, 1'b0);
        chk("t6_waiting", done, 1'b0);
        chk("t6_a_oe", a_oe, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_done", done, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_passthru_bit_tx.md
# i2c_passthru_bit_tx

Per-bit SDA transmitter for the I2C passthrough: the drive-side counterpart of the passthrough rx/tx controller. On each controller start pulse it takes the bit value sampled on the source channel and reproduces it on the target channel's SDA, master side (A) or slave side (B). It holds the bit through one full SCL low-high-low cycle of that channel plus a hold interval, then reports completion. It sits between the controller (`i_start`, `i_tx_to_mst`, `o_tx_done`) and the open-drain SDA pad enables.

## Interface
- `HOLD_CYC`, default 4: i_clk cycles SDA is held after target SCL falls before `o_tx_done`; legal range 0..65535.
- `TIMEOUT_CYC`, default 50000: max wait cycles in any wait state; 1..65535; used only with the macro.
- `i_clk`, input, 1: clock.
- `i_rst`, input, 1: reset, synchronous, active-high.
- `i_start`, input, 1: one-cycle bit-start pulse from the controller.
- `i_tx_to_mst`, input, 1: 1 = drive channel A (master side), 0 = drive channel B (slave side); sampled with `i_start`.
- `i_abort`, input, 1: start/stop detected on either channel; cancels the current bit.
- `i_bit_valid`, input, 1: source-side bit value is valid.
- `i_bit`, input, 1: source-side bit value.
- `i_cha_scl`, `i_cha_sda`, `i_chb_scl`, `i_chb_sda`, input, 1 each: synchronized line levels.
- `o_cha_sda_oe`, `o_chb_sda_oe`, output, 1 each: 1 = pull SDA low.
- `o_tx_done`, output, 1: level; high while idle.
- `o_sda_mismatch`, output, 1: one-cycle pulse when a released (1) bit reads 0 on the target.
- `o_timeout`, output, 1: one-cycle pulse on wait timeout; tied 0 without the macro.

## Operation
- All outputs are registered. Reset values: both `oe` = 0, `o_tx_done` = 1, all pulses 0, state IDLE, counter 0, sel 0.
- Priority per cycle: `i_rst` > `i_abort` > normal transitions.
- `i_abort` in any state: both `oe` go to 0 and the block returns to IDLE the next cycle with `o_tx_done` = 1.
- Target channel: `sel` selects A when 1, B when 0. `tgt_scl` and `tgt_sda` are the selected channel's lines.
- States:
  - **IDLE**: `o_tx_done` = 1. `oe` keep their last value, which provides hold across the bit boundary. On `i_start`: latch sel ← `i_tx_to_mst`, go to WAIT_VAL. `i_start` outside IDLE is ignored.
  - **WAIT_VAL**: on `i_bit_valid`, latch bit ← `i_bit`, go to LOAD.
  - **LOAD**: wait for `tgt_scl` = 0. Then set the target `oe` ← ~bit and the other channel's `oe` ← 0, go to WAIT_RISE.
  - **WAIT_RISE**: on `tgt_scl` = 1, go to WAIT_FALL. On the first cycle in WAIT_FALL, if bit = 1 and `tgt_sda` = 0, pulse `o_sda_mismatch` (at most once per bit).
  - **WAIT_FALL**: on `tgt_scl` = 0, clear the counter and go to HOLD. If `HOLD_CYC` = 0, go straight to IDLE instead.
  - **HOLD**: count up; when count = `HOLD_CYC`-1, go to IDLE.
- Counter: 16-bit unsigned, no wrap. It saturates at 65535.

## Timing
- `o_tx_done` falls the cycle after an accepted `i_start`.
- `i_bit_valid` seen in WAIT_VAL → `oe` updates 2 cycles later if `tgt_scl` is already 0.
- After `tgt_scl` = 0 is seen in WAIT_FALL, `o_tx_done` rises `HOLD_CYC`+1 cycles later (1 cycle when `HOLD_CYC` = 0).
- `i_start` arriving in the same cycle `o_tx_done` rises is accepted.
- `i_abort` and `i_start` in the same cycle: abort wins and the start is dropped.

## Configuration
- `I2C_PASSTHRU_BIT_TX_TIMEOUT_EN`, defined:
  - A wait counter restarts on entry to WAIT_VAL, LOAD, WAIT_RISE and WAIT_FALL.
  - Reaching `TIMEOUT_CYC` releases both `oe`, pulses `o_timeout` and returns to IDLE.
- Undefined: the wait states wait indefinitely, `o_timeout` is tied 0, and no wait-counter logic is built.

## Structure
- Shared package/include `i2c_passthru_pkg`: state encodings (IDLE=0 … HOLD=5, 3 bits) and the 16-bit counter width constant; shared with the rx/tx controller.
- One sub-module, `i2c_passthru_cyc_cnt`: saturating 16-bit counter with clear/enable and a terminal-match output. It is instantiated for HOLD, and for timeout when the macro is enabled.

## Test plan
- Bit 0 to B: `i_tx_to_mst`=0, `i_bit`=0, B SCL low→high→low → `o_chb_sda_oe`=1 from LOAD, `o_cha_sda_oe`=0, `o_tx_done` high exactly 5 cycles after SCL falls (`HOLD_CYC`=4).
- Bit 1 to A with A SDA forced 0 during SCL high → `o_cha_sda_oe`=0, a single `o_sda_mismatch` pulse.
- Direction switch: bit 0 to B, then bit 0 to A → at the second LOAD `o_chb_sda_oe` 1→0 and `o_cha_sda_oe` 0→1 in the same cycle.
- `i_abort` during WAIT_FALL with `oe`=1 → next cycle both `oe`=0 and `o_tx_done`=1. `i_start`+`i_abort` in the same cycle → stays IDLE.
- `HOLD_CYC`=0: `o_tx_done` rises 1 cycle after target SCL falls. `i_start` issued while busy is ignored.
- With `I2C_PASSTHRU_BIT_TX_TIMEOUT_EN` and `TIMEOUT_CYC`=100, SCL stuck high → `o_timeout` pulses at the 100th WAIT_FALL cycle, both `oe`=0, `o_tx_done`=1.
